wb_dnsize_64to32: RTL and testbench
===================================

Name: wb_dnsize_64to32

Overview:
- Wishbone 64-to-32-bit downsizer directly downstream of the core's Wishbone master port (wbm_* of the S1 top level).
- Splits each 64-bit classic-cycle access into one or two 32-bit accesses, based on the byte selects, on the narrow peripheral/memory bus.
- Reassembles read data and returns a single ack to the master.
- Includes a bus-timeout watchdog so a dead slave cannot hang the core.

Parameters:
- ADDR_W, 32, width of narrow-side byte address.
- TIMEOUT, 1024, cycles without narrow ack before a half-transfer is abandoned; 0 disables the watchdog.

Ports:
- sys_clock_i  in  1  system clock; all logic on rising edge.
- sys_reset_i  in  1  synchronous, active-high reset.
- wbs_cycle_i  in  1  master cycle.
- wbs_strobe_i  in  1  master strobe.
- wbs_we_i  in  1  master write enable.
- wbs_addr_i  in  64  master byte address; bits [2:0] ignored.
- wbs_data_i  in  64  master write data; big-endian, [63:32] at the lower address.
- wbs_sel_i  in  8  byte selects; sel[7] pairs with data[63:56].
- wbs_ack_o  out  1  single-cycle ack to master.
- wbs_data_o  out  64  read data, valid when wbs_ack_o=1.
- wbn_cycle_o  out  1  narrow cycle.
- wbn_strobe_o  out  1  narrow strobe.
- wbn_we_o  out  1  narrow write enable.
- wbn_addr_o  out  ADDR_W  narrow byte address; bits [1:0] always 0.
- wbn_data_o  out  32  narrow write data.
- wbn_sel_o  out  4  narrow byte selects.
- wbn_ack_i  in  1  narrow ack.
- wbn_data_i  in  32  narrow read data.
- timeout_o  out  1  pulses with wbs_ack_o when any half timed out.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; read-data register and timeout counter cleared. Reset mid-transfer drops narrow cyc/stb on the next edge and sends no ack to the master.
- States: IDLE, HI, LO, DONE. All outputs are registered.
- IDLE, on cyc&stb:
  - sel[7:4]!=0 -> HI.
  - else sel[3:0]!=0 -> LO.
  - else (sel=0) -> DONE; no narrow access, data_o=0.
  - Latch we, addr, data and sel at this point.
- HI phase:
  - Drive cyc=stb=1, addr={addr[ADDR_W-1:3],3'b000}, data=wdata[63:32], sel=sel[7:4].
  - On wbn_ack_i, capture wbn_data_i into rdata[63:32] (reads only).
  - Then -> LO if sel[3:0]!=0, else -> DONE.
  - HI->LO keeps cyc and stb high; the address, data and sel change on the cycle after the ack.
- LO phase:
  - Drive addr={addr[ADDR_W-1:3],3'b100}, data=wdata[31:0], sel=sel[3:0].
  - On ack, capture into rdata[31:0], then -> DONE.
- DONE:
  - Narrow cyc/stb=0.
  - wbs_ack_o=1 for exactly one cycle, with wbs_data_o=rdata; unselected byte lanes read as 0.
  - -> IDLE.
  - The new request is not sampled in DONE, so back-to-back requests cost one IDLE cycle.
- Latency, with a narrow slave acking N cycles after stb rises (N>=1): the master ack arrives N+2 cycles after request acceptance for one half, 2N+3 for two halves.
- Writes: wbs_data_o=0 at ack.
- Timeout:
  - The counter resets on each half start and counts while waiting.
  - At count==TIMEOUT-1 with no ack, abandon the half: its rdata lanes = all ones, set timeout flag, proceed as if acked. The other half is still attempted.
  - timeout_o=1 only in the DONE cycle; the flag is cleared in IDLE.
- Master abort: wbs_cycle_i=0 during HI/LO -> IDLE next edge; narrow cyc/stb drop, no ack, and any late narrow ack is ignored.
- A narrow ack in IDLE or DONE is ignored.

Test Plan:
- Read, addr 0x1000, sel 0xFF; slave returns 0xAABBCCDD @0x1000, 0x11223344 @0x1004 with N=1 -> two narrow reads in address order; wbs_data_o=0xAABBCCDD11223344; ack 5 cycles after acceptance; timeout_o=0.
- Write, addr 0x2008, sel 0x0F, data 0x0123456789ABCDEF -> single narrow write @0x200C, data 0x89ABCDEF, sel 0xF; one master ack.
- Byte read, sel 0x80 @0x3000; slave returns 0x5A000000 -> one narrow read @0x3000 with sel 0x8; wbs_data_o=0x5A00000000000000.
- sel=0x00 -> no narrow cyc; ack 1 cycle after acceptance; data 0.
- TIMEOUT=16, sel 0xFF, slave never acks the high half but acks the low half with 0x00000007 -> high half abandoned after 16 cycles; data 0xFFFFFFFF00000007; timeout_o=1 with ack.
- Reset asserted while in HI; also cyc dropped during LO -> narrow cyc=0 next cycle; no wbs_ack_o; the next request completes normally.

Source files
------------

// File: rtl/wb_dnsize_64to32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : wb_dnsize_64to32
//  Description : Wishbone classic 64-bit to 32-bit downsizer. Each master
//                access becomes zero, one or two narrow accesses (high word
//                first, at the lower address), read data is reassembled and
//                a single ack is returned. A watchdog abandons a half that
//                is never acked, so a dead slave cannot stall the core.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_dnsize_64to32 #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              sys_clock_i,
   input  logic              sys_reset_i,
   input  logic              wbs_cycle_i,
   input  logic              wbs_strobe_i,
   input  logic              wbs_we_i,
   input  logic [63:0]       wbs_addr_i,
   input  logic [63:0]       wbs_data_i,
   input  logic [7:0]        wbs_sel_i,
   output logic              wbs_ack_o,
   output logic [63:0]       wbs_data_o,
   output logic              wbn_cycle_o,
   output logic              wbn_strobe_o,
   output logic              wbn_we_o,
   output logic [ADDR_W-1:0] wbn_addr_o,
   output logic [31:0]       wbn_data_o,
   output logic [3:0]        wbn_sel_o,
   input  logic              wbn_ack_i,
   input  logic [31:0]       wbn_data_i,
   output logic              timeout_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HI   = 2'd1;
   localparam logic [1:0] S_LO   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]        r_state;
   logic [1:0]        w_next;

   // request captured on acceptance
   logic              r_we;
   logic [ADDR_W-4:0] r_addr;
   logic [63:0]       r_wdata;
   logic [7:0]        r_sel;

   // reassembled read data and sticky timeout flag
   logic [63:0]       r_rdata;
   logic              r_tflag;

   logic              w_busy;
   logic              w_tmo;
   logic              w_half_end;

   // request source: live inputs while idle, captured copy afterwards
   logic              w_we_src;
   logic [ADDR_W-4:0] w_addr_src;
   logic [63:0]       w_wdata_src;
   logic [7:0]        w_sel_src;
   logic [63:0]       w_mask;

   // next values of the registered outputs and datapath
   logic [63:0]       w_rdata_n;
   logic              w_tflag_n;
   logic              w_cyc_n;
   logic              w_we_n;
   logic [ADDR_W-1:0] w_addr_n;
   logic [31:0]       w_ndata_n;
   logic [3:0]        w_nsel_n;
   logic              w_ack_n;
   logic [63:0]       w_sdata_n;
   logic              w_tout_n;

   // byte-address bits [2:0] and bits above ADDR_W carry no meaning here
   logic              w_unused_addr;
   assign w_unused_addr = ^wbs_addr_i;

   assign w_busy     = (r_state == S_HI) || (r_state == S_LO);
   // a half finishes on a narrow ack or on watchdog expiry, unless aborted
   assign w_half_end = w_busy && wbs_cycle_i && (wbn_ack_i || w_tmo);

   generate
      if (TIMEOUT > 0) begin : g_wdog
         logic [TCW-1:0] r_tcnt;

         // restart on every state change (each half start), count while waiting
         always_ff @(posedge sys_clock_i) begin
            if (sys_reset_i) begin
               r_tcnt <= '0;
            end else if ((w_next != r_state) || !w_busy) begin
               r_tcnt <= '0;
            end else begin
               r_tcnt <= r_tcnt + 1'b1;
            end
         end

         assign w_tmo = w_busy && !wbn_ack_i && (r_tcnt == TCW'(TIMEOUT - 1));
      end else begin : g_nowdog
         assign w_tmo = 1'b0;
      end
   endgenerate

   // state register
   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state logic: dispatch on byte selects, master abort beats narrow ack
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (wbs_cycle_i && wbs_strobe_i) begin
               if (|wbs_sel_i[7:4]) begin
                  w_next = S_HI;
               end else if (|wbs_sel_i[3:0]) begin
                  w_next = S_LO;
               end else begin
                  w_next = S_DONE;
               end
            end
         end
         S_HI: begin
            if (!wbs_cycle_i) begin
               w_next = S_IDLE;
            end else if (w_half_end) begin
               w_next = (|r_sel[3:0]) ? S_LO : S_DONE;
            end
         end
         S_LO: begin
            if (!wbs_cycle_i) begin
               w_next = S_IDLE;
            end else if (w_half_end) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // output logic: next values of every registered output, from next state
   always_comb begin
      w_we_src    = (r_state == S_IDLE) ? wbs_we_i                   : r_we;
      w_addr_src  = (r_state == S_IDLE) ? wbs_addr_i[ADDR_W-1:3]     : r_addr;
      w_wdata_src = (r_state == S_IDLE) ? wbs_data_i                 : r_wdata;
      w_sel_src   = (r_state == S_IDLE) ? wbs_sel_i                  : r_sel;

      for (int i = 0; i < 8; i++) begin
         w_mask[8*i +: 8] = {8{w_sel_src[i]}};
      end

      w_rdata_n = r_rdata;
      w_tflag_n = r_tflag;
      if (r_state == S_IDLE) begin
         w_rdata_n = '0;
         w_tflag_n = 1'b0;
      end else if (w_half_end) begin
         if (wbn_ack_i) begin
            if (!r_we) begin
               if (r_state == S_HI) begin
                  w_rdata_n[63:32] = wbn_data_i;
               end else begin
                  w_rdata_n[31:0] = wbn_data_i;
               end
            end
         end else begin
            // abandoned half reads as all ones
            w_tflag_n = 1'b1;
            if (r_state == S_HI) begin
               w_rdata_n[63:32] = '1;
            end else begin
               w_rdata_n[31:0] = '1;
            end
         end
      end

      w_cyc_n   = (w_next == S_HI) || (w_next == S_LO);
      w_we_n    = 1'b0;
      w_addr_n  = '0;
      w_ndata_n = '0;
      w_nsel_n  = '0;
      if (w_next == S_HI) begin
         w_we_n    = w_we_src;
         w_addr_n  = {w_addr_src, 3'b000};
         w_ndata_n = w_wdata_src[63:32];
         w_nsel_n  = w_sel_src[7:4];
      end else if (w_next == S_LO) begin
         w_we_n    = w_we_src;
         w_addr_n  = {w_addr_src, 3'b100};
         w_ndata_n = w_wdata_src[31:0];
         w_nsel_n  = w_sel_src[3:0];
      end

      w_ack_n   = (w_next == S_DONE);
      w_sdata_n = (w_ack_n && !w_we_src) ? (w_rdata_n & w_mask) : 64'd0;
      w_tout_n  = w_ack_n && w_tflag_n;
   end

   // registered outputs, request capture and read-data assembly
   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_sel        <= '0;
         r_rdata      <= '0;
         r_tflag      <= 1'b0;
         wbs_ack_o    <= 1'b0;
         wbs_data_o   <= '0;
         wbn_cycle_o  <= 1'b0;
         wbn_strobe_o <= 1'b0;
         wbn_we_o     <= 1'b0;
         wbn_addr_o   <= '0;
         wbn_data_o   <= '0;
         wbn_sel_o    <= '0;
         timeout_o    <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_we    <= wbs_we_i;
            r_addr  <= wbs_addr_i[ADDR_W-1:3];
            r_wdata <= wbs_data_i;
            r_sel   <= wbs_sel_i;
         end
         r_rdata      <= w_rdata_n;
         r_tflag      <= w_tflag_n;
         wbs_ack_o    <= w_ack_n;
         wbs_data_o   <= w_sdata_n;
         wbn_cycle_o  <= w_cyc_n;
         wbn_strobe_o <= w_cyc_n;
         wbn_we_o     <= w_we_n;
         wbn_addr_o   <= w_addr_n;
         wbn_data_o   <= w_ndata_n;
         wbn_sel_o    <= w_nsel_n;
         timeout_o    <= w_tout_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_dnsize_64to32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wb_dnsize_64to32
//  Description : Self-checking bench for wb_dnsize_64to32. A narrow slave
//                with programmable ack latency logs every access; a
//                transaction-level model predicts accesses, data, latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_dnsize_64to32;

   localparam int TMO = 16;

   typedef struct packed {
      logic [31:0] a;
      logic        w;
      logic [3:0]  s;
      logic [31:0] d;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [63:0] adr = '0, dat = '0;
   logic [7:0]  sel = '0;
   logic        ack, tmo;
   logic [63:0] dato;
   logic        ncyc, nstb, nwe;
   logic [31:0] nadr, ndato;
   logic [3:0]  nsel;
   logic        s_ack = 1'b0;
   logic [31:0] s_dat = '0;

   int          n_total = 0;
   int          n_bad   = 0;

   // slave behaviour controls
   int          s_lat   = 1;
   int          s_cnt   = 0;
   logic        dead_en = 1'b0;
   logic [31:0] dead_addr = '0;

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   acc_t        slog[$];
   acc_t        elog[$];

   logic [63:0] exp_data;
   logic        exp_tmo;
   int          exp_lat;

   wb_dnsize_64to32 #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
      .sys_clock_i (clk),
      .sys_reset_i (rst),
      .wbs_cycle_i (cyc),
      .wbs_strobe_i(stb),
      .wbs_we_i    (we),
      .wbs_addr_i  (adr),
      .wbs_data_i  (dat),
      .wbs_sel_i   (sel),
      .wbs_ack_o   (ack),
      .wbs_data_o  (dato),
      .wbn_cycle_o (ncyc),
      .wbn_strobe_o(nstb),
      .wbn_we_o    (nwe),
      .wbn_addr_o  (nadr),
      .wbn_data_o  (ndato),
      .wbn_sel_o   (nsel),
      .wbn_ack_i   (s_ack),
      .wbn_data_i  (s_dat),
      .timeout_o   (tmo)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // narrow slave: acks s_lat cycles after seeing a request, one-cycle ack
   always @(posedge clk) begin
      logic [31:0] wd;
      if (rst) begin
         s_ack <= 1'b0;
         s_cnt <= 0;
      end else if (s_ack) begin
         s_ack <= 1'b0;
         s_cnt <= 0;
      end else if (ncyc && nstb && !(dead_en && nadr == dead_addr)) begin
         if (s_cnt + 1 >= s_lat) begin
            s_ack <= 1'b1;
            s_cnt <= 0;
            slog.push_back('{a: nadr, w: nwe, s: nsel, d: nwe ? ndato : 32'd0});
            if (nwe) begin
               wd = mem_rd(nadr);
               for (int b = 0; b < 4; b++)
                  if (nsel[b]) wd[8*b +: 8] = ndato[8*b +: 8];
               mem[nadr] = wd;
               s_dat <= 32'd0;
            end else begin
               s_dat <= mem_rd(nadr);
            end
         end else begin
            s_cnt <= s_cnt + 1;
         end
      end else begin
         s_cnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_total++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // transaction-level prediction: narrow accesses, read data, timeout, latency
   task automatic model(input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] s, input int n);
      logic [31:0] base, ha, word, wv;
      logic [3:0]  hs;
      elog.delete();
      exp_data = 64'd0;
      exp_tmo  = 1'b0;
      exp_lat  = 1;
      base     = {a[31:3], 3'b000};
      for (int h = 0; h < 2; h++) begin
         ha = base + (h == 0 ? 32'd0 : 32'd4);
         hs = (h == 0) ? s[7:4] : s[3:0];
         wv = (h == 0) ? d[63:32] : d[31:0];
         word = 32'd0;
         if (hs != 4'd0) begin
            if (dead_en && ha == dead_addr) begin
               exp_tmo = 1'b1;
               exp_lat += TMO;
               word = 32'hFFFF_FFFF;
            end else begin
               exp_lat += n + 1;
               elog.push_back('{a: ha, w: w, s: hs, d: w ? wv : 32'd0});
               word = ref_rd(ha);
               if (w) begin
                  for (int b = 0; b < 4; b++)
                     if (hs[b]) word[8*b +: 8] = wv[8*b +: 8];
                  ref_mem[ha] = word;
               end
            end
            for (int b = 0; b < 4; b++)
               if (!hs[b]) word[8*b +: 8] = 8'h00;
         end
         if (!w) begin
            if (h == 0) exp_data[63:32] = word;
            else        exp_data[31:0]  = word;
         end
      end
   endtask

   task automatic do_txn(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] s, input int n, input string tag);
      int          lat = 0;
      logic        got = 1'b0;
      logic [63:0] rd  = '0;
      logic        to  = 1'b0;
      s_lat = n;
      model(a, w, d, s, n);
      slog.delete();
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      @(posedge clk);
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (ack) begin
            lat = k; got = 1'b1; rd = dato; to = tmo;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 8'd0;
      chk({tag, "_ack_seen"}, got, 1'b1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_rdata"}, rd, exp_data);
      chk({tag, "_timeout"}, to, exp_tmo);
      @(negedge clk);
      chk({tag, "_ack_pulse"}, ack, 1'b0);
      chk({tag, "_n_access"}, slog.size(), elog.size());
      for (int i = 0; i < slog.size() && i < elog.size(); i++)
         chk({tag, "_access"}, slog[i], elog[i]);
   endtask

   initial begin
      int   found;
      logic seen;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", ack, 1'b0);
      chk("rst_data", dato, 64'd0);
      chk("rst_ncyc", {ncyc, nstb, nwe}, 3'd0);
      chk("rst_nbus", {nadr, ndato, nsel}, 68'd0);
      chk("rst_tmo", tmo, 1'b0);

      // directed cases
      mem[32'h1000] = 32'hAABBCCDD; ref_mem[32'h1000] = 32'hAABBCCDD;
      mem[32'h1004] = 32'h11223344; ref_mem[32'h1004] = 32'h11223344;
      do_txn(64'h1000, 1'b0, 64'd0, 8'hFF, 1, "rd_full");
      chk("rd_full_value", exp_data, 64'hAABBCCDD11223344);

      do_txn(64'h2008, 1'b1, 64'h0123456789ABCDEF, 8'h0F, 1, "wr_low");
      chk("wr_low_mem", mem_rd(32'h200C), 32'h89ABCDEF);

      mem[32'h3000] = 32'h5A000000; ref_mem[32'h3000] = 32'h5A000000;
      do_txn(64'h3000, 1'b0, 64'd0, 8'h80, 2, "rd_byte");
      chk("rd_byte_value", exp_data, 64'h5A00000000000000);

      do_txn(64'h3008, 1'b0, 64'hFFFF, 8'h00, 1, "sel_zero");

      dead_en = 1'b1; dead_addr = 32'h5000;
      mem[32'h5004] = 32'h7; ref_mem[32'h5004] = 32'h7;
      do_txn(64'h5000, 1'b0, 64'd0, 8'hFF, 1, "timeout");
      chk("timeout_value", exp_data, 64'hFFFFFFFF00000007);
      dead_en = 1'b0;

      // reset while the high half is outstanding
      s_lat = 6;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 64'h6000; sel = 8'hF0;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rst_hi_busy", ncyc, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_hi_ncyc", ncyc, 1'b0);
      chk("rst_hi_ack", ack, 1'b0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; sel = 8'd0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | ack;
      end
      chk("rst_hi_no_ack", seen, 1'b0);

      // master abort during the low half
      s_lat = 3;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 64'h1000; sel = 8'hFF;
      found = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ncyc && nadr[2]) begin
            found = 1;
            break;
         end
      end
      chk("abort_reach_lo", found, 1);
      cyc = 1'b0; stb = 1'b0; sel = 8'd0;
      @(negedge clk);
      chk("abort_ncyc", {ncyc, nstb}, 2'b00);
      seen = ack;
      repeat (8) begin
         @(negedge clk);
         seen = seen | ack;
      end
      chk("abort_no_ack", seen, 1'b0);
      do_txn(64'h1000, 1'b0, 64'd0, 8'hFF, 1, "after_abort");
      chk("after_abort_value", exp_data, 64'hAABBCCDD11223344);

      // randomized traffic over a small window so reads revisit written words
      for (int t = 0; t < 30; t++) begin
         logic [63:0] ra, rdv;
         logic [7:0]  rs;
         logic        rw;
         int          pick;
         ra   = 64'h4000 + 64'(8 * $urandom_range(0, 7));
         rw   = 1'($urandom_range(0, 1));
         rdv  = {$urandom, $urandom};
         pick = $urandom_range(0, 5);
         case (pick)
            0:       rs = 8'h00;
            1:       rs = 8'h0F;
            2:       rs = 8'hF0;
            default: rs = 8'($urandom);
         endcase
         do_txn(ra, rw, rdv, rs, $urandom_range(1, 4), "rand");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=expired required=finish");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
